tcdm_bank_ctrl: RTL
===================

# tcdm_bank_ctrl

Single-bank TCDM slave controller. It terminates one exploded TCDM slave port (req/addr/wen/data/be/gnt/r_data/r_valid/r_ready) and drives a single-port SRAM macro with 1-cycle read latency. Read data is buffered in a response FIFO so the master can backpressure with `r_ready`. Grant is credit-gated so a granted read can never overflow the FIFO. FIFO status is exported as `mem_pkg::flags_fifo_t`.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: TCDM and SRAM data width. Must be a multiple of 8.
- `ADDR_WIDTH`, default 32: TCDM byte-address width.
- `MEM_ADDR_WIDTH`, default 10: SRAM word-address width.
- `RSP_DEPTH`, default 2: response FIFO depth. Legal range 1..256.

**Ports**
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `tcdm_req_i` in 1: request.
- `tcdm_addr_i` in `ADDR_WIDTH`: byte address.
- `tcdm_wen_i` in 1: 1 = write, 0 = read.
- `tcdm_data_i` in `DATA_WIDTH`: write data.
- `tcdm_be_i` in `DATA_WIDTH/8`: byte enables.
- `tcdm_gnt_o` out 1: request accepted this cycle.
- `tcdm_r_data_o` out `DATA_WIDTH`: read data, taken from the FIFO head.
- `tcdm_r_valid_o` out 1: FIFO is non-empty.
- `tcdm_r_ready_i` in 1: master accepts the response.
- `mem_req_o` out 1: SRAM access strobe.
- `mem_we_o` out 1: SRAM write enable.
- `mem_addr_o` out `MEM_ADDR_WIDTH`: SRAM word address.
- `mem_wdata_o` out `DATA_WIDTH`: SRAM write data.
- `mem_be_o` out `DATA_WIDTH/8`: SRAM byte enables.
- `mem_rdata_i` in `DATA_WIDTH`: SRAM read data, valid the cycle after a read strobe.
- `flags_o` out `mem_pkg::flags_fifo_t`: response FIFO status.

## Operation

**Address mapping**
- `mem_addr_o = tcdm_addr_i[$clog2(DATA_WIDTH/8) +: MEM_ADDR_WIDTH]`.
- Upper bits are ignored; bank decode is done upstream.

**Credit counter `cnt`** (range 0..`RSP_DEPTH`)
- Counts FIFO entries plus an in-flight read, if any.
- Increments on a read grant.
- Decrements on a pop (`r_valid & r_ready`).
- Both in one cycle: `cnt` holds.

**Grant**
- `pop = tcdm_r_valid_o & tcdm_r_ready_i`.
- `tcdm_gnt_o = !rst_i & tcdm_req_i & (tcdm_wen_i | cnt < RSP_DEPTH | pop)`.
- Writes are always granted and consume no credit.
- Writes produce no response.

**SRAM side**
- `mem_req_o = tcdm_gnt_o`.
- `mem_we_o`, `mem_wdata_o`, `mem_be_o` are passed through combinationally from the TCDM inputs.

**Response path**
- A granted read sets the `rd_pending` register.
- In the next cycle, `mem_rdata_i` is written at `push_pointer`.
- The FIFO is a circular buffer. Pointers wrap from `RSP_DEPTH-1` to 0.
- Push and pop in the same cycle are both performed.
- Responses are returned strictly in grant order.

**Flags**
- `empty = (entries == 0)`.
- `full = (entries == RSP_DEPTH)`.
- `full` reflects entries only, not the in-flight read.
- Pointers are zero-extended to 8 bits.

**Reset**
- Reset in any cycle flushes the FIFO and zeroes `cnt`, `rd_pending` and both pointers.
- An in-flight read's data is discarded.
- Registered outputs after reset: `tcdm_r_valid_o = 0`, `flags_o = {empty:1, full:0, ptrs:0}`.
- Combinational outputs while `rst_i = 1`: `tcdm_gnt_o = 0`, `mem_req_o = 0`.

## Timing

- **Read latency:** a read granted in cycle N has `tcdm_r_valid_o = 1` in cycle N+2 at the earliest (SRAM in N+1, FIFO registered).
- **Write:** completes in the grant cycle. A read of the same address in the next cycle returns the new data.
- **Throughput:** one read per cycle sustained when `RSP_DEPTH >= 2` and `r_ready` stays high. With `RSP_DEPTH = 1`, one read every 2 cycles.
- **Backpressure:**
  - `tcdm_r_data_o` stays stable while `r_valid & !r_ready`.
  - The master may hold `req` across cycles. The controller never drops a granted request.
- **Mixed traffic:** a write may be granted while a read is in flight. The SRAM is accessed at most once per cycle by construction.

## Test plan

- **Reset:** assert `rst_i` with `tcdm_req_i = 1` and `wen = 0` for 3 cycles.
  - Expect `gnt = 0`, `mem_req_o = 0`, `r_valid = 0`, and `flags.empty = 1` throughout.
- **Single read:** SRAM word 5 = 0xDEADBEEF. Read `addr = 0x14` at cycle N.
  - `gnt = 1` and `mem_addr_o = 5` at N.
  - `r_valid = 1` with `r_data = 0xDEADBEEF` at N+2.
- **Streaming:** 8 back-to-back reads to words 0..7 with `r_ready = 1` and `RSP_DEPTH = 2`.
  - `gnt = 1` on all 8 cycles.
  - Data returns in order on 8 consecutive cycles.
- **Backpressure:** `r_ready = 0`, `RSP_DEPTH = 2`, `req` held for reads.
  - Exactly 2 grants, then `gnt = 0`, then `flags.full = 1`.
  - Raise `r_ready`: `gnt` returns in the same cycle as the first pop.
  - A write request is still granted while reads are blocked.
- **Write then read:** write 0x11223344 with `be = 4'b0011` to word 3 (old value 0xAAAAAAAA), then read it next cycle.
  - `r_data = 0xAAAA3344`.
- **Wrap and reset:** with `RSP_DEPTH = 3`, perform 7 reads with irregular `r_ready`.
  - Pointers wrap 2→0 and all data is ordered.
  - Assert `rst_i` while `rd_pending = 1`: no response for that read emerges after reset, and `flags_o` returns to empty.

Source files
------------

// File: rtl/tcdm_bank_ctrl.sv
// tcdm_bank_ctrl: single-bank TCDM slave in front of a 1-cycle-latency SRAM,
// with a credit-gated response FIFO so the master can backpressure reads.
package mem_pkg;
   typedef struct packed {
      logic       empty;
      logic       full;
      logic [7:0] push_pointer;
      logic [7:0] pop_pointer;
   } flags_fifo_t;
endpackage

module tcdm_bank_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 10,
   parameter int unsigned RSP_DEPTH      = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      tcdm_req_i,
   input  logic [ADDR_WIDTH-1:0]     tcdm_addr_i,
   input  logic                      tcdm_wen_i,
   input  logic [DATA_WIDTH-1:0]     tcdm_data_i,
   input  logic [DATA_WIDTH/8-1:0]   tcdm_be_i,
   output logic                      tcdm_gnt_o,
   output logic [DATA_WIDTH-1:0]     tcdm_r_data_o,
   output logic                      tcdm_r_valid_o,
   input  logic                      tcdm_r_ready_i,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]   mem_be_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
   output mem_pkg::flags_fifo_t      flags_o
);
   localparam int unsigned OFS = $clog2(DATA_WIDTH / 8);
   localparam int unsigned PW  = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);

   if (DATA_WIDTH % 8 != 0 || RSP_DEPTH < 1 || RSP_DEPTH > 256) begin : g_bad_param
      $error("tcdm_bank_ctrl: illegal DATA_WIDTH or RSP_DEPTH");
   end

   logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
   logic [PW-1:0]         push_ptr, pop_ptr;
   logic [CW-1:0]         cnt, entries;
   logic                  rd_pending, pop, rd_gnt;
   logic                  addr_unused;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign addr_unused    = ^tcdm_addr_i;
   assign pop            = tcdm_r_valid_o & tcdm_r_ready_i;
   // a pop frees a credit in the same cycle, so a full pipeline keeps streaming
   assign tcdm_gnt_o     = !rst_i & tcdm_req_i & (tcdm_wen_i | cnt < CW'(RSP_DEPTH) | pop);
   assign rd_gnt         = tcdm_gnt_o & !tcdm_wen_i;
   assign mem_req_o      = tcdm_gnt_o;
   assign mem_we_o       = tcdm_wen_i;
   assign mem_addr_o     = tcdm_addr_i[OFS +: MEM_ADDR_WIDTH];
   assign mem_wdata_o    = tcdm_data_i;
   assign mem_be_o       = tcdm_be_i;
   assign tcdm_r_valid_o = entries != '0;
   assign tcdm_r_data_o  = fifo[pop_ptr];

   always_comb begin
      flags_o.empty        = entries == '0;
      flags_o.full         = entries == CW'(RSP_DEPTH);
      flags_o.push_pointer = 8'(push_ptr);
      flags_o.pop_pointer  = 8'(pop_ptr);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt        <= '0;
         entries    <= '0;
         rd_pending <= 1'b0;
         push_ptr   <= '0;
         pop_ptr    <= '0;
      end else begin
         rd_pending <= rd_gnt;
         cnt        <= cnt + CW'(rd_gnt) - CW'(pop);
         entries    <= entries + CW'(rd_pending) - CW'(pop);
         if (rd_pending) push_ptr <= wrap_inc(push_ptr);
         if (pop) pop_ptr <= wrap_inc(pop_ptr);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && rd_pending) fifo[push_ptr] <= mem_rdata_i;
   end

   credit_bound: assert property (@(posedge clk_i) disable iff (rst_i) cnt <= CW'(RSP_DEPTH));
   no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i)
                                 rd_pending |-> (entries < CW'(RSP_DEPTH) || pop));
endmodule
